// File: rtl/multi_sum_uart_pkg.sv
// Shared types and helpers for the multi-operand sum UART transmitter.
package multi_sum_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

  localparam int unsigned UART_FRAME_BITS = 10;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < value) r++;
    return r;
  endfunction

  function automatic int unsigned bytes_for(input int unsigned width);
    return (width + 7) / 8;
  endfunction

endpackage

// File: rtl/multi_sum_uart_tx_byte.sv
// One 8N1 UART frame per start pulse; done pulses during the last stop-bit cycle.
module uart_tx_byte
  import multi_sum_uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       txd,
  output logic       done
);

  localparam int unsigned CNT_W = clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLK_DIV - 2);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             txd_q, txd_d;
  logic             done_q, done_d;
  logic             bit_end_c;

  assign bit_end_c = (cnt_q == CNT_LAST);

  // A start in the final stop cycle chains straight into the next frame.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    txd_d   = txd_q;
    done_d  = 1'b0;
    if (start) begin
      state_d = ST_START;
      cnt_d   = '0;
      bit_d   = '0;
      shreg_d = data;
      txd_d   = 1'b0;
    end else begin
      case (state_q)
        ST_START: begin
          if (bit_end_c) begin
            cnt_d   = '0;
            state_d = ST_DATA;
            txd_d   = shreg_q[0];
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_end_c) begin
            cnt_d = '0;
            if (bit_q == 3'd7) begin
              state_d = ST_STOP;
              txd_d   = 1'b1;
            end else begin
              bit_d   = bit_q + 1'b1;
              shreg_d = shreg_q >> 1;
              txd_d   = shreg_q[1];
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_STOP: begin
          done_d = (cnt_q == CNT_PRE);
          if (bit_end_c) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          txd_d   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      txd_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      txd_q   <= txd_d;
      done_q  <= done_d;
    end
  end

  assign txd  = txd_q;
  assign done = done_q;

endmodule

// File: rtl/multi_sum_uart_tx.sv
// Latches NUM_OPS operands from save buttons, sums them, and sends the sum
// LSB byte first over an 8N1 UART.
module multi_sum_uart_tx
  import multi_sum_uart_pkg::*;
#(
  parameter  int unsigned DATA_W    = 3,
  parameter  int unsigned NUM_OPS   = 4,
  parameter  int unsigned CLK_DIV   = 434,
  localparam int unsigned RES_W     = DATA_W + clog2(NUM_OPS),
  localparam int unsigned NUM_BYTES = bytes_for(RES_W)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_OPS-1:0] save_n,
  input  logic [DATA_W-1:0]  data_input,
  input  logic               uart_tx_en,
  output logic               uart_txd,
  output logic               uart_tx_busy,
  output logic [NUM_OPS-1:0] op_valid,
  output logic [RES_W-1:0]   sum_out
);

  localparam int unsigned PAD_W = NUM_BYTES * 8;
  localparam int unsigned IDX_W = (NUM_BYTES > 1) ? clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BYTES - 1);

  logic [NUM_OPS-1:0] save_s1_q, save_s2_q, save_s3_q;
  logic [DATA_W-1:0]  data_s1_q, data_s2_q;
  logic [DATA_W-1:0]  operand_q [NUM_OPS];
  logic [DATA_W-1:0]  operand_d [NUM_OPS];
  logic [NUM_OPS-1:0] op_valid_q, op_valid_d;
  logic [RES_W-1:0]   sum_out_q, sum_out_d;
  tx_state_e          state_q, state_d;
  logic [IDX_W-1:0]   byte_idx_q, byte_idx_d;
  logic               busy_q, busy_d;

  logic [NUM_OPS-1:0] save_fall_c;
  logic [RES_W-1:0]   sum_c;
  logic [PAD_W-1:0]   sum_pad_c, snap_pad_c;
  logic               byte_start_c;
  logic [7:0]         byte_data_c;
  logic               byte_done;
  logic               byte_txd;

  assign save_fall_c = save_s3_q & ~save_s2_q;
  assign sum_pad_c   = PAD_W'(sum_c);
  assign snap_pad_c  = PAD_W'(sum_out_q);

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < int'(NUM_OPS); i++) sum_c = sum_c + RES_W'(operand_q[i]);
  end

  // Sequencer parks in ST_START while uart_tx_byte walks the bits of each byte.
  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    busy_d       = busy_q;
    sum_out_d    = sum_out_q;
    op_valid_d   = op_valid_q;
    operand_d    = operand_q;
    byte_start_c = 1'b0;
    byte_data_c  = '0;
    case (state_q)
      ST_IDLE: begin
        if (&op_valid_q && uart_tx_en) begin
          state_d = ST_LOAD;
          busy_d  = 1'b1;
        end
      end
      ST_LOAD: begin
        sum_out_d    = sum_c;
        op_valid_d   = '0;
        byte_idx_d   = '0;
        byte_start_c = 1'b1;
        byte_data_c  = sum_pad_c[7:0];
        state_d      = ST_START;
      end
      ST_START: begin
        if (byte_done) begin
          if (byte_idx_q == IDX_LAST) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end else begin
            byte_idx_d   = byte_idx_q + 1'b1;
            byte_start_c = 1'b1;
            for (int k = 1; k < int'(NUM_BYTES); k++) begin
              if (IDX_W'(k) == byte_idx_d) byte_data_c = snap_pad_c[k*8 +: 8];
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A save edge overrides the LOAD clear so it counts toward the next round.
    for (int i = 0; i < int'(NUM_OPS); i++) begin
      if (save_fall_c[i]) begin
        operand_d[i]  = data_s2_q;
        op_valid_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      save_s1_q  <= '1;
      save_s2_q  <= '1;
      save_s3_q  <= '1;
      data_s1_q  <= '0;
      data_s2_q  <= '0;
      for (int i = 0; i < int'(NUM_OPS); i++) operand_q[i] <= '0;
      op_valid_q <= '0;
      sum_out_q  <= '0;
      state_q    <= ST_IDLE;
      byte_idx_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      save_s1_q  <= save_n;
      save_s2_q  <= save_s1_q;
      save_s3_q  <= save_s2_q;
      data_s1_q  <= data_input;
      data_s2_q  <= data_s1_q;
      operand_q  <= operand_d;
      op_valid_q <= op_valid_d;
      sum_out_q  <= sum_out_d;
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      busy_q     <= busy_d;
    end
  end

  uart_tx_byte #(
    .CLK_DIV(CLK_DIV)
  ) u_tx_byte (
    .clk  (clk),
    .rst_n(reset_n),
    .start(byte_start_c),
    .data (byte_data_c),
    .txd  (byte_txd),
    .done (byte_done)
  );

  assign uart_txd     = byte_txd;
  assign uart_tx_busy = busy_q;
  assign op_valid     = op_valid_q;
  assign sum_out      = sum_out_q;

endmodule
